// File: rtl/i2c_slave_ram_port_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_ram_port_if
//   Bundles the I2C pins and the two RAM ports of i2c_slave_ram_port.
//
//   Signals:
//     slaveAddr       7-bit bus address the slave answers to
//     scl_in, sda_in  raw (unsynchronised) I2C lines
//     sda_oe          1 = pull SDA low, 0 = release (open drain)
//     masterRAM_*     write port into the master RAM (address, data, strobe)
//     slaveRAM_RADD   read address into the slave RAM
//     slaveRAM_DOUT   slave RAM read data, valid 1 clk after RADD changes
//     busy            high from an address match until STOP or NACK
//
//   Handshake: there is no valid/ready pair. masterRAM_W is a one-clk strobe
//   that qualifies masterRAM_WADD/masterRAM_DIN in the same clk; the RAM
//   must accept every strobe. The slave RAM read port has no enable: the
//   engine holds slaveRAM_RADD and samples slaveRAM_DOUT two clks later.
//
//   Modports: slave = protocol engine side, master = environment side.
// ----------------------------------------------------------------------------
interface i2c_slave_ram_port_if;
    logic [6:0] slaveAddr;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [4:0] masterRAM_WADD;
    logic [7:0] masterRAM_DIN;
    logic       masterRAM_W;
    logic [4:0] slaveRAM_RADD;
    logic [7:0] slaveRAM_DOUT;
    logic       busy;

    modport slave (
        input  slaveAddr, scl_in, sda_in, slaveRAM_DOUT,
        output sda_oe, masterRAM_WADD, masterRAM_DIN, masterRAM_W,
               slaveRAM_RADD, busy
    );

    modport master (
        output slaveAddr, scl_in, sda_in, slaveRAM_DOUT,
        input  sda_oe, masterRAM_WADD, masterRAM_DIN, masterRAM_W,
               slaveRAM_RADD, busy
    );
endinterface

// File: rtl/i2c_slave_ram_port.sv
// ----------------------------------------------------------------------------
// i2c_slave_ram_port
//   I2C slave protocol engine. Bytes written by the bus master go to the
//   master RAM write port; bytes read by the bus master come from the slave
//   RAM read port. A persistent 5-bit auto-incrementing pointer addresses
//   both RAMs; the first byte of every write transfer reloads it.
//
//   Ports:
//     clk      system clock, at least 10x SCL
//     reset_n  asynchronous active-low reset
//     bus      i2c_slave_ram_port_if.slave (pins + RAM ports)
//     state_o  FSM state for observation:
//              0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WR_DATA, 4 WR_ACK,
//              5 RD_LOAD, 6 RD_DATA, 7 RD_ACK, 8 WAIT_STOP
//     ptr_o    current RAM pointer
// ----------------------------------------------------------------------------
module i2c_slave_ram_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    i2c_slave_ram_port_if.slave        bus,
    output logic [3:0]                 state_o,
    output logic [4:0]                 ptr_o
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, WR_DATA = 4'd3, WR_ACK = 4'd4,
        RD_LOAD = 4'd5, RD_DATA = 4'd6, RD_ACK = 4'd7, WAIT_STOP = 4'd8
    } state_t;

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // ---------------- synchronisers and event detection ----------------
    // Reset to 1 (idle bus) so leaving reset never fakes a START or STOP.
    logic [NS-1:0] scl_sync_q, sda_sync_q;
    logic          scl_prev_q, sda_prev_q;
    logic          scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[NS-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[NS-2:0], bus.sda_in};
            scl_prev_q <= scl_sync_q[NS-1];
            sda_prev_q <= sda_sync_q[NS-1];
        end
    end

    assign scl_s    = scl_sync_q[NS-1];
    assign sda_s    = sda_sync_q[NS-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & ~sda_prev_q & sda_s;

    // ---------------- state and datapath registers ----------------
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;      // next write byte is the pointer byte
    logic [4:0]  ptr_q, ptr_d;
    logic        inc_pend_q, inc_pend_d; // bump ptr the clk after a RAM write
    logic        ld_cnt_q, ld_cnt_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [4:0]  wadd_q, wadd_d;
    logic [7:0]  din_q, din_d;
    logic        w_q, w_d;
    logic [4:0]  radd_q, radd_d;
    logic        addr_match;

    assign addr_match = (shift_q[7:1] == bus.slaveAddr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            ptr_q      <= '0;
            inc_pend_q <= 1'b0;
            ld_cnt_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wadd_q     <= '0;
            din_q      <= '0;
            w_q        <= 1'b0;
            radd_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            ptr_q      <= ptr_d;
            inc_pend_q <= inc_pend_d;
            ld_cnt_q   <= ld_cnt_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wadd_q     <= wadd_d;
            din_q      <= din_d;
            w_q        <= w_d;
            radd_q     <= radd_d;
        end
    end

    // ---------------- next state ----------------
    // STOP beats START, and both beat any SCL edge in the same clk.
    always_comb begin
        state_d = state_q;
        if (stop_ev) begin
            state_d = IDLE;
        end else if (start_ev) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:     if (scl_fall && bit_cnt_q == 4'd8)
                              state_d = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (rw_q && scl_rise)       state_d = RD_LOAD;
                          else if (!rw_q && scl_fall) state_d = WR_DATA;
                WR_DATA:  if (scl_fall && bit_cnt_q == 4'd8) state_d = WR_ACK;
                WR_ACK:   if (scl_fall) state_d = WR_DATA;
                RD_LOAD:  if (ld_cnt_q) state_d = RD_DATA;
                RD_DATA:  if (scl_fall && bit_cnt_q == 4'd8) state_d = RD_ACK;
                RD_ACK:   if (scl_rise) state_d = sda_s ? WAIT_STOP : RD_LOAD;
                IDLE, WAIT_STOP: state_d = state_q;
                default:  state_d = IDLE;
            endcase
        end
    end

    // ---------------- datapath / outputs ----------------
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        first_d    = first_q;
        ptr_d      = inc_pend_q ? ptr_q + 5'd1 : ptr_q;
        inc_pend_d = 1'b0;
        ld_cnt_d   = 1'b0;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wadd_d     = wadd_q;
        din_d      = din_q;
        w_d        = 1'b0;
        radd_d     = radd_q;
        if (stop_ev) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start_ev) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = addr_match;
                        busy_d    = addr_match;
                        if (addr_match) rw_d = shift_q[0];
                    end
                end
                ADDR_ACK: begin
                    if (rw_q && scl_rise) begin
                        radd_d = ptr_q;             // prefetch inside the ACK clock
                    end else if (!rw_q && scl_fall) begin
                        sda_oe_d  = 1'b0;
                        first_d   = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                WR_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (first_q) begin
                                ptr_d   = {shift_q[3:0], sda_s};
                                first_d = 1'b0;
                            end else begin
                                wadd_d     = ptr_q;
                                din_d      = {shift_q[6:0], sda_s};
                                w_d        = 1'b1;
                                inc_pend_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;           // data bytes are always ACKed
                        bit_cnt_d = '0;
                    end
                end
                WR_ACK: if (scl_fall) sda_oe_d = 1'b0;
                RD_LOAD: begin
                    bit_cnt_d = '0;
                    if (!ld_cnt_q) ld_cnt_d = 1'b1;
                    else           shift_d  = bus.slaveRAM_DOUT;
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q != 4'd8) begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;        // let the master drive ACK/NACK
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ptr_d = ptr_q + 5'd1;
                        if (!sda_s) radd_d = ptr_q + 5'd1;
                        else        busy_d = 1'b0;
                    end
                end
                IDLE, WAIT_STOP: sda_oe_d = 1'b0;
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign bus.sda_oe         = sda_oe_q;
    assign bus.busy           = busy_q;
    assign bus.masterRAM_WADD = wadd_q;
    assign bus.masterRAM_DIN  = din_q;
    assign bus.masterRAM_W    = w_q;
    assign bus.slaveRAM_RADD  = radd_q;
    assign state_o            = state_q;
    assign ptr_o              = ptr_q;
endmodule

// File: tb/tb_i2c_slave_ram_port.sv
module tb_i2c_slave_ram_port;
  localparam logic [3:0] S_IDLE = 4'd0, S_ADDR = 4'd1, S_WR_DATA = 4'd3,
                         S_RD_DATA = 4'd6, S_WAIT_STOP = 4'd8;
  localparam int NV = 19;

  typedef enum int {OP_START, OP_STOP, OP_WR, OP_RD} op_t;
  typedef struct {
    op_t        op;
    logic [7:0] data;
    logic       mack;
    logic       exp_ack;
    logic [7:0] exp_rd;
    logic [3:0] exp_state;
    logic       exp_busy;
    logic [4:0] exp_ptr;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       sda_m;
  logic [3:0] state_dbg;
  logic [4:0] ptr_dbg;
  logic [7:0] mem [32];

  int n_vec = 0;
  int n_err = 0;
  int w_long = 0;
  int oe_cnt = 0;
  logic w_prev = 1'b0;
  logic watch_oe = 1'b0;

  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];

  i2c_slave_ram_port_if bus();

  i2c_slave_ram_port #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .state_o (state_dbg),
    .ptr_o   (ptr_dbg)
  );

  // open-drain wired-AND of master and slave
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous-read slave RAM model
  always @(posedge clk) bus.slaveRAM_DOUT <= mem[bus.slaveRAM_RADD];

  // write monitor and sda_oe watcher
  always @(negedge clk) begin
    if (bus.masterRAM_W === 1'b1) begin
      got_q.push_back({bus.masterRAM_WADD, bus.masterRAM_DIN});
      if (w_prev) w_long++;
    end
    w_prev = (bus.masterRAM_W === 1'b1);
    if (watch_oe && bus.sda_oe === 1'b1) oe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    clks(4); sda_m = b;
    clks(4); bus.scl_in = 1'b1;
    clks(4); s = bus.sda_in;
    clks(4); bus.scl_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    logic [7:0] t;
    t = '0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      t[i] = s;
    end
    send_bit(~mack, s);
    d = t;
  endtask

  task automatic start_cond();
    clks(4); sda_m = 1'b1;
    clks(4); bus.scl_in = 1'b1;
    clks(4); sda_m = 1'b0;
    clks(4); bus.scl_in = 1'b0;
  endtask

  task automatic stop_cond();
    clks(4); sda_m = 1'b0;
    clks(4); bus.scl_in = 1'b1;
    clks(4); sda_m = 1'b1;
    clks(4);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " sda_oe"}, 32'(bus.sda_oe), 32'd0);
    check({tag, " W"},      32'(bus.masterRAM_W), 32'd0);
    check({tag, " WADD"},   32'(bus.masterRAM_WADD), 32'd0);
    check({tag, " DIN"},    32'(bus.masterRAM_DIN), 32'd0);
    check({tag, " RADD"},   32'(bus.slaveRAM_RADD), 32'd0);
    check({tag, " busy"},   32'(bus.busy), 32'd0);
    check({tag, " state"},  32'(state_dbg), 32'(S_IDLE));
    check({tag, " ptr"},    32'(ptr_dbg), 32'd0);
  endtask

  initial begin
    vec_t vecs[NV];
    logic ack;
    logic [7:0] rd;
    int nw;

    // write 0x1E,0xAA,0xBB; addr mismatch; ptr=3 then read 3 bytes
    vecs[0]  = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, S_ADDR,      1'b0, 5'h00};
    vecs[1]  = '{OP_WR,    8'h84, 1'b0, 1'b1, 8'h00, S_WR_DATA,   1'b1, 5'h00};
    vecs[2]  = '{OP_WR,    8'h1E, 1'b0, 1'b1, 8'h00, S_WR_DATA,   1'b1, 5'h1E};
    vecs[3]  = '{OP_WR,    8'hAA, 1'b0, 1'b1, 8'h00, S_WR_DATA,   1'b1, 5'h1F};
    vecs[4]  = '{OP_WR,    8'hBB, 1'b0, 1'b1, 8'h00, S_WR_DATA,   1'b1, 5'h00};
    vecs[5]  = '{OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, S_IDLE,      1'b0, 5'h00};
    vecs[6]  = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, S_ADDR,      1'b0, 5'h00};
    vecs[7]  = '{OP_WR,    8'h86, 1'b0, 1'b0, 8'h00, S_WAIT_STOP, 1'b0, 5'h00};
    vecs[8]  = '{OP_WR,    8'h55, 1'b0, 1'b0, 8'h00, S_WAIT_STOP, 1'b0, 5'h00};
    vecs[9]  = '{OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, S_IDLE,      1'b0, 5'h00};
    vecs[10] = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, S_ADDR,      1'b0, 5'h00};
    vecs[11] = '{OP_WR,    8'h84, 1'b0, 1'b1, 8'h00, S_WR_DATA,   1'b1, 5'h00};
    vecs[12] = '{OP_WR,    8'h03, 1'b0, 1'b1, 8'h00, S_WR_DATA,   1'b1, 5'h03};
    vecs[13] = '{OP_START, 8'h00, 1'b0, 1'b0, 8'h00, S_ADDR,      1'b1, 5'h03};
    vecs[14] = '{OP_WR,    8'h85, 1'b0, 1'b1, 8'h00, S_RD_DATA,   1'b1, 5'h03};
    vecs[15] = '{OP_RD,    8'h00, 1'b1, 1'b0, 8'h11, S_RD_DATA,   1'b1, 5'h04};
    vecs[16] = '{OP_RD,    8'h00, 1'b1, 1'b0, 8'h22, S_RD_DATA,   1'b1, 5'h05};
    vecs[17] = '{OP_RD,    8'h00, 1'b0, 1'b0, 8'h33, S_WAIT_STOP, 1'b0, 5'h06};
    vecs[18] = '{OP_STOP,  8'h00, 1'b0, 1'b0, 8'h00, S_IDLE,      1'b0, 5'h06};

    exp_q.push_back({5'h1E, 8'hAA});
    exp_q.push_back({5'h1F, 8'hBB});

    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
    mem[3] = 8'h11;
    mem[4] = 8'h22;
    mem[5] = 8'h33;
    mem[7] = 8'h00;

    reset_n = 1'b0;
    bus.scl_in = 1'b1;
    sda_m = 1'b1;
    bus.slaveAddr = 7'h42;
    clks(4);
    reset_n = 1'b1;
    clks(4);
    check_outputs_zero("reset");

    // table-driven transactions
    for (int i = 0; i < NV; i++) begin
      watch_oe = (i >= 6 && i <= 9);
      case (vecs[i].op)
        OP_START: start_cond();
        OP_STOP:  stop_cond();
        OP_WR: begin
          send_byte(vecs[i].data, ack);
          check($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].exp_ack));
        end
        OP_RD: begin
          read_byte(vecs[i].mack, rd);
          check($sformatf("v%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end
        default: ;
      endcase
      clks(6);
      check($sformatf("v%0d state", i), 32'(state_dbg), 32'(vecs[i].exp_state));
      check($sformatf("v%0d busy", i),  32'(bus.busy),  32'(vecs[i].exp_busy));
      check($sformatf("v%0d ptr", i),   32'(ptr_dbg),   32'(vecs[i].exp_ptr));
    end
    watch_oe = 1'b0;
    check("mismatch sda_oe cycles", 32'(oe_cnt), 32'd0);

    // START in the middle of a data byte: no write, back to ADDR
    start_cond();
    send_byte(8'h84, ack);
    check("midbyte addr ack", 32'(ack), 32'd1);
    send_byte(8'h07, ack);
    check("midbyte ptr ack", 32'(ack), 32'd1);
    nw = got_q.size();
    begin
      logic s;
      send_bit(1'b1, s);
      send_bit(1'b0, s);
      send_bit(1'b1, s);
      send_bit(1'b1, s);
    end
    start_cond();
    clks(6);
    check("midbyte state", 32'(state_dbg), 32'(S_ADDR));
    check("midbyte writes", 32'(got_q.size()), 32'(nw));
    check("midbyte ptr", 32'(ptr_dbg), 32'h07);

    // next address (read) handled normally; mem[7]=0 so SDA is pulled low
    send_byte(8'h85, ack);
    check("read addr ack", 32'(ack), 32'd1);
    clks(6);
    check("read state", 32'(state_dbg), 32'(S_RD_DATA));
    check("read sda_oe", 32'(bus.sda_oe), 32'd1);

    // asynchronous reset while driving SDA
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async release sda_oe", 32'(bus.sda_oe), 32'd0);
    bus.scl_in = 1'b1;
    sda_m = 1'b1;
    clks(3);
    @(negedge clk);
    reset_n = 1'b1;
    clks(4);
    check_outputs_zero("post-reset");

    // STOP and SCL rise in the same clk: STOP wins
    start_cond();
    clks(4);
    bus.scl_in = 1'b1;
    sda_m = 1'b1;
    clks(8);
    check("stop+rise state", 32'(state_dbg), 32'(S_IDLE));
    check("stop+rise busy", 32'(bus.busy), 32'd0);
    start_cond();
    send_byte(8'h84, ack);
    check("after stop+rise ack", 32'(ack), 32'd1);
    clks(6);
    check("after stop+rise state", 32'(state_dbg), 32'(S_WR_DATA));
    stop_cond();
    clks(6);
    check("final state", 32'(state_dbg), 32'(S_IDLE));

    // scoreboard
    check("write count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [12:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("write addr/data", 32'(g), 32'(e));
    end
    check("W strobe width", 32'(w_long), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
